instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h01000000, byte address of the first fetch after reset.
REQ-002 Parameter IMEM_BASE, 32'h01000000, lowest legal instruction byte address.
REQ-003 Parameter IMEM_LAST, 32'h010007FC, highest legal instruction word byte address.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr_addr  out  [31:2]  word address to instruction memory, combinational; memory registers it and returns data one cycle later.
REQ-007 instr  in  32  instruction memory read data for the address latched at the previous edge.
REQ-008 redirect_valid  in  1  branch/jump redirect request, single-cycle pulse or level.
REQ-009 redirect_pc  in  32  redirect target byte address.
REQ-010 out_valid  out  1  fetched instruction valid to decode.
REQ-011 out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
REQ-012 out_pc  out  32  byte address of out_instr.
REQ-013 out_instr  out  32  fetched instruction.
REQ-014 out_fault  out  1  fetch fault (misaligned or out-of-range) for the current out_pc.

Function
REQ-015 State: req_pc [31:2] (address currently latched in memory), req_mis (misalign flag), state FSM {BOOT, RUN}; BOOT = no valid response in memory.
REQ-016 instr_addr priority: rst -> RESET_PC[31:2]; else redirect_valid -> redirect_pc[31:2]; else BOOT -> req_pc; else RUN && !out_ready -> req_pc (hold); else req_pc + 1.
REQ-017 Every edge with rst low: req_pc <= instr_addr; state <= RUN.
REQ-018 Redirect edge: req_mis <= (redirect_pc[1:0] != 0); any other non-reset edge with an address change: req_mis <= 0; hold keeps req_mis.
REQ-019 req_pc + 1 wraps modulo 2^30; no saturation.
REQ-020 out_valid = (state == RUN) && !redirect_valid && !rst.
REQ-021 out_pc = {req_pc, 2'b00}.
REQ-022 out_fault = out_valid && (req_mis || out_pc < IMEM_BASE || out_pc > IMEM_LAST).
REQ-023 out_instr = out_fault-condition ? 32'h00000013 (NOP) : instr; fault condition evaluated without out_valid gating.
REQ-024 Stall: while out_valid && !out_ready, out_pc, out_instr, out_fault stable cycle to cycle (memory re-reads held address).
REQ-025 Throughput: one instruction per cycle with out_ready held high; redirect-to-first-valid latency 1 cycle.
REQ-026 Redirect kills the response present in the same cycle (out_valid forced 0), regardless of out_ready.
REQ-027 Redirect during stall: stall released, target fetched; held instruction discarded.
REQ-028 out_valid must not drop without a transfer except on redirect or rst.

Reset
REQ-029 rst edge: state <= BOOT, req_pc <= RESET_PC[31:2], req_mis <= 0; overrides redirect and stall.
REQ-030 While rst high: out_valid = 0, out_fault = 0, instr_addr = RESET_PC[31:2].
REQ-031 First cycle after rst release: BOOT, out_valid = 0, instr_addr = 30'h00400000; second cycle: out_valid = 1, out_pc = 32'h01000000.

Verification
REQ-032 Release rst, out_ready=1 -> cycle 1 out_valid=0; cycle 2 out_pc=0x01000000, out_instr=imem word 0x01000000; then 0x01000004, 0x01000008 on consecutive cycles.
REQ-033 out_ready=0 for 3 cycles at out_pc=0x01000008 -> instr_addr=0x00400002 held, outputs stable; out_ready=1 -> next cycle out_pc=0x0100000C.
REQ-034 redirect_valid=1, redirect_pc=0x01000100 while out_valid=1 -> out_valid=0 that cycle; next cycle out_pc=0x01000100, out_valid=1.
REQ-035 redirect_pc=0x01000102 -> next cycle out_fault=1, out_pc=0x01000100, out_instr=0x00000013; sequential fetch 0x010007FC then 0x01000800 -> second has out_fault=1.
REQ-036 rst asserted together with redirect_valid during a stall -> next cycle state BOOT, out_valid=0, instr_addr=0x00400000; redirect ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect request and decode handshake.
interface instr_fetch_if;
    logic [31:2] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    // Fetch unit side
    modport master (
        output instr_addr,
        input  instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_fault
    );

    // Memory / redirect source / decode side
    modport slave (
        input  instr_addr,
        output instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a registered-read instruction memory and
// presents one instruction per cycle to decode, with stall, redirect and
// range/alignment fault detection.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
    parameter logic [31:0] IMEM_LAST = 32'h0100_07FC
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int unsigned WORD_W = 30;
    localparam logic [WORD_W-1:0] RESET_WORD = RESET_PC[31:2];
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // BOOT: memory holds no response yet; RUN: memory output is a live fetch
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_req_pc;
    logic                r_req_mis;
    logic [WORD_W-1:0]   w_addr;
    logic                w_req_mis_nxt;
    logic [31:0]         w_out_pc;
    logic                w_fault_cond;
    logic                w_out_valid;

    // State register: address latched into memory, misalign flag, FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BOOT;
            r_req_pc  <= RESET_WORD;
            r_req_mis <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_pc  <= w_addr;
            r_req_mis <= w_req_mis_nxt;
        end
    end

    // Next fetch address, next state and decode-side outputs
    always_comb begin
        w_state_nxt   = ST_RUN;
        w_addr        = r_req_pc + WORD_W'(1);
        w_req_mis_nxt = 1'b0;
        w_out_pc      = {r_req_pc, 2'b00};
        w_out_valid   = 1'b0;
        w_fault_cond  = 1'b0;

        if (rst) begin
            w_state_nxt   = ST_BOOT;
            w_addr        = RESET_WORD;
            w_req_mis_nxt = 1'b0;
        end else if (bus.redirect_valid) begin
            w_addr        = bus.redirect_pc[31:2];
            w_req_mis_nxt = (bus.redirect_pc[1:0] != 2'b00);
        end else if (r_state == ST_BOOT) begin
            // First fetch still in flight: re-present the same address
            w_addr        = r_req_pc;
            w_req_mis_nxt = r_req_mis;
        end else if (!bus.out_ready) begin
            // Stall: memory re-reads the held address so outputs stay stable
            w_addr        = r_req_pc;
            w_req_mis_nxt = r_req_mis;
        end

        w_out_valid  = (r_state == ST_RUN) && !bus.redirect_valid && !rst;
        w_fault_cond = r_req_mis || (w_out_pc < IMEM_BASE) || (w_out_pc > IMEM_LAST);
    end

    // Decode-side and memory-side outputs
    assign bus.instr_addr = w_addr;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_pc     = w_out_pc;
    assign bus.out_fault  = w_out_valid && w_fault_cond;
    assign bus.out_instr  = w_fault_cond ? NOP_INSTR : bus.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a registered-read memory model, a queue of
// expected transfers checked by a monitor, and inline checks for killed
// cycles, stalls and reset behaviour.
module tb_instr_fetch;

    logic clk;
    logic rst;
    logic [29:0] r_mem_addr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a recognisable word derived from the address
    function automatic logic [31:0] imem(input logic [29:0] wa);
        return {wa, 2'b01} ^ 32'hA5A5_0000;
    endfunction

    // Registered-read instruction memory
    always @(posedge clk) r_mem_addr <= bus.instr_addr;
    assign bus.instr = imem(r_mem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_ok(input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.instr = imem(pc[31:2]); e.fault = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_fault(input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.instr = 32'h0000_0013; e.fault = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must match the head of the queue
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer_pc", bus.out_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", bus.out_pc, e.pc);
                chk("xfer_instr", bus.out_instr, e.instr);
                chk("xfer_fault", 32'(bus.out_fault), 32'(e.fault));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset, with a redirect asserted to show reset priority
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0100;
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fault", 32'(bus.out_fault), 32'd0);
        chk("rst_addr", 32'(bus.instr_addr), 32'h0040_0000);
        tick();
        bus.redirect_valid = 1'b0;

        // Boot cycle
        tick();
        rst = 1'b0;
        push_ok(32'h0100_0000);
        push_ok(32'h0100_0004);
        push_ok(32'h0100_0008);
        @(negedge clk);
        chk("boot_valid", 32'(bus.out_valid), 32'd0);
        chk("boot_addr", 32'(bus.instr_addr), 32'h0040_0000);

        tick();   // 0x01000000
        @(negedge clk);
        chk("run_valid", 32'(bus.out_valid), 32'd1);
        tick();   // 0x01000004

        // Three stall cycles at 0x01000008
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_addr", 32'(bus.instr_addr), 32'h0040_0002);
            chk("stall_pc", bus.out_pc, 32'h0100_0008);
            chk("stall_instr", bus.out_instr, imem(30'h0040_0002));
            chk("stall_fault", 32'(bus.out_fault), 32'd0);
        end
        tick();   // release: 0x01000008 transfers
        bus.out_ready = 1'b1;
        push_ok(32'h0100_000C);
        tick();   // 0x0100000C

        // Redirect kills the 0x01000010 response
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0100;
        push_ok(32'h0100_0100);
        @(negedge clk);
        chk("redir_kill_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", 32'(bus.instr_addr), 32'h0040_0040);
        tick();   // 0x01000100
        bus.redirect_valid = 1'b0;

        // Misaligned redirect
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0102;
        push_fault(32'h0100_0100);
        push_ok(32'h0100_0104);
        @(negedge clk);
        chk("mis_kill_valid", 32'(bus.out_valid), 32'd0);
        tick();   // 0x01000100 faulted
        bus.redirect_valid = 1'b0;
        tick();   // 0x01000104, misalign cleared

        // Upper range boundary
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_07FC;
        push_ok(32'h0100_07FC);
        push_fault(32'h0100_0800);
        push_fault(32'h0100_0804);
        @(negedge clk);
        chk("hi_kill_valid", 32'(bus.out_valid), 32'd0);
        tick();   // 0x010007FC
        bus.redirect_valid = 1'b0;
        tick();   // 0x01000800
        tick();   // 0x01000804

        // Stall, then reset together with redirect
        tick();
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0100;
        @(negedge clk);
        chk("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stall_fault", 32'(bus.out_fault), 32'd0);
        chk("rst_stall_addr", 32'(bus.instr_addr), 32'h0040_0000);
        tick();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        push_ok(32'h0100_0000);
        @(negedge clk);
        chk("reboot_valid", 32'(bus.out_valid), 32'd0);
        chk("reboot_addr", 32'(bus.instr_addr), 32'h0040_0000);
        tick();   // 0x01000000

        // Wrap at the top of the address space; both words out of range
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        push_fault(32'hFFFF_FFFC);
        push_fault(32'h0000_0000);
        @(negedge clk);
        chk("wrap_kill_valid", 32'(bus.out_valid), 32'd0);
        tick();   // 0xFFFFFFFC
        bus.redirect_valid = 1'b0;
        tick();   // 0x00000000
        @(negedge clk);
        chk("wrap_addr", 32'(bus.instr_addr), 32'h0000_0001);

        // Drain and confirm every expected transfer was seen
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
